resource_pool_arbiter: RTL and testbench
========================================

// Module: resource_pool_arbiter
// PURPOSE
//  Lock arbiter for one class of shared execution resource (ALU pool or memory port) contended by SICs.
//  - Owns NUM_UNITS identical units; receives one rpl_req per SIC; hands each unit to at most one SIC.
//  - A grant is held until the owner pulses release_lock.
//  - Priority is oldest issue_id first (wrap-aware), so the oldest in-flight instruction never starves.
//  - Instantiated once per pool (ALU, MEM) between the SIC array and the resource datapath mux.
// PARAMETERS
//  NUM_REQ    4  number of requesting SICs
//  NUM_UNITS  1  identical units in the pool (1..NUM_REQ)
//  ID_WIDTH   4  issue_id width; the in-flight id window must be < 2**(ID_WIDTH-1)
// PORTS
//  clk           input   1                      clock, single domain
//  rst           input   1                      asynchronous, active-high reset
//  rpl_in        input   rpl_req#(ID_WIDTH)::t [NUM_REQ]   per SIC: req, req_issue_id, release_lock
//  grant         output  [NUM_REQ]              registered; SIC i currently owns a unit
//  grant_unit    output  [NUM_REQ][UW]          unit index owned by SIC i, valid while grant[i]; UW=max(1,$clog2(NUM_UNITS))
//  unit_busy     output  [NUM_UNITS]            unit u has an owner
//  unit_owner    output  [NUM_UNITS][RW]        owning SIC index of unit u; RW=max(1,$clog2(NUM_REQ)); drives datapath mux
// BEHAVIOUR
//  Reset (async, rst=1): all units FREE.
//  - grant=0, grant_unit=0, unit_busy=0, unit_owner=0.
//  - Reset mid-ownership drops every grant immediately; SICs are reset by the same event.
//  Per-unit state: FREE | HELD(owner). Owner registers are the only architectural state.
//  Release:
//  - release_lock[i] while unit u is HELD by i -> u FREE at the next edge.
//  - release_lock from a non-owner is ignored; SICs abort before grant and still pulse release.
//  - A HELD unit stays HELD even when its owner's req drops. SICs drop req one cycle before pulsing release.
//  Candidates: SIC i with req[i]=1 and grant[i]=0.
//  Free view: units FREE now, plus units being released this cycle (bypass).
//  - So release in cycle t -> new owner's grant high in cycle t+1, with no dead cycle.
//  Allocation each cycle:
//  - Sort candidates oldest-first; assign the k-th oldest to the k-th lowest-indexed free unit.
//  - Up to NUM_UNITS grants per cycle.
//  Age compare: a older than b iff (a-b) mod 2**ID_WIDTH has MSB set. This is correct across id wrap.
//  Equal ids (illegal) tie-break to the lower SIC index.
//  Latency: req high in cycle t with a free unit -> grant high in t+1.
//  - grant stays high until the edge after the owner's release_lock.
//  A SIC owns at most one unit; a held owner's req is never re-arbitrated.
//  A candidate that drops req before winning is simply no longer considered; no state is kept for it.
//  Release and new request by the same SIC in the same cycle:
//  - The release is processed; the SIC becomes a candidate next cycle.
//  - This cannot occur with the SIC FSM and is not required to win.
//  Assertions (sim only):
//  - never two units with the same owner;
//  - grant[i] implies unit_owner[grant_unit[i]]==i;
//  - unit_busy matches popcount(grant).
// STRUCTURE
//  structs.svh / shared package:
//  - function id_older(a,b) (wrap-aware, ID_WIDTH-generic);
//  - typedef pool_unit_state_t {busy, owner}.
//  Sub-module age_priority_select:
//  - combinational, NUM_REQ candidates -> oldest-first one-hot picks for NUM_UNITS slots;
//  - built from pairwise id_older rank counting: rank_i = number of older candidates.
//  Top: owner registers, release decode, free-view bypass, registered grant/grant_unit derived from owners.
// TESTING
//  1 Solo: NUM_UNITS=1, SIC0 req id=3 at t0 -> grant[0]=1 at t1; release at t5 -> grant[0]=0 at t6, unit_busy=0.
//  2 Age:
//    - SIC0 id=7, SIC2 id=5 request the same cycle -> SIC2 granted.
//    - SIC2 releases -> SIC0 granted the cycle after the release pulse.
//  3 Wrap: ID_WIDTH=4, SIC1 id=15, SIC3 id=1 -> SIC1 wins (15 older than 1).
//  4 Bypass: owner SIC0 releases in cycle t while SIC1 waits -> grant[1]=1 at t+1; no cycle where both are high.
//  5 Pool:
//    - NUM_UNITS=2, SICs 0..3 with ids 4,2,6,3 request together -> SIC1 on unit0, SIC3 on unit1; others wait.
//    - Stray release from SIC2 (non-owner) -> no change.
//  6 Reset: assert rst while 2 units are held -> all outputs 0 asynchronously; after deassert, a fresh req is granted in 1 cycle.

Source files
------------

// File: rtl/resource_pool_arbiter_pkg.sv
// Shared types and helpers for the resource pool arbiter.
//   pool_unit_state_t : per-unit architectural state (busy flag + owning SIC index)
//   id_older()        : wrap-aware issue-id age compare, usable for any id width up to 32
//   RPL_* localparams : bit layout of one SIC's request word on rpl_in
package resource_pool_arbiter_pkg;

    // Owner field is sized for the largest supported requester count; the top
    // only ever loads indices below NUM_REQ into it.
    localparam int POOL_OWNER_W = 8;

    typedef struct packed {
        logic                    busy;
        logic [POOL_OWNER_W-1:0] owner;
    } pool_unit_state_t;

    // Request word layout, LSB first: release_lock, req_issue_id[ID_WIDTH], req.
    localparam int RPL_REL_BIT = 0;
    localparam int RPL_ID_LSB  = 1;

    // a is older than b when (a - b) mod 2**width has its MSB set. Doing the
    // subtraction in 32 bits and looking at bit width-1 gives the same bit.
    function automatic logic id_older(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input int unsigned width);
        return 1'((a - b) >> (width - 1));
    endfunction

endpackage

// File: rtl/resource_pool_arbiter_age_priority_select.sv
// Combinational oldest-first selector.
//   cand : candidate mask (req and not already granted)
//   ids  : issue id per requester
//   pick : pick[k] is one-hot on the k-th oldest candidate, zero if fewer than k+1 candidates
// Each candidate's rank is the number of candidates strictly older than it;
// equal ids rank the lower requester index as older, so ranks are unique.
module resource_pool_arbiter_age_priority_select
    import resource_pool_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_UNITS = 1,
    parameter int ID_WIDTH  = 4
) (
    input  logic [NUM_REQ-1:0]                   cand,
    input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]     ids,
    output logic [NUM_UNITS-1:0][NUM_REQ-1:0]    pick
);

    localparam int RKW = $clog2(NUM_REQ + 1);

    logic [RKW-1:0] rank [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j != i && cand[j]) begin
                    if (id_older(32'(ids[j]), 32'(ids[i]), ID_WIDTH) ||
                        (ids[j] == ids[i] && j < i)) begin
                        rank[i] = rank[i] + RKW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        pick = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pick[k][i] = cand[i] && (rank[i] == RKW'(k));
            end
        end
    end

endmodule

// File: rtl/resource_pool_arbiter.sv
// Lock arbiter for one pool of identical shared units contended by NUM_REQ SICs.
// A unit is handed to the oldest waiting SIC (wrap-aware issue id) and held until
// the owner pulses release_lock; a unit being released is re-grantable in the same cycle.
// Ports:
//   clk, rst    : clock; asynchronous active-high reset (frees every unit)
//   rpl_in[i]   : {req, req_issue_id[ID_WIDTH-1:0], release_lock} from SIC i
//   grant[i]    : SIC i owns a unit (registered)
//   grant_unit  : unit index owned by SIC i, zero while grant[i] is low
//   unit_busy   : unit u has an owner
//   unit_owner  : owning SIC of unit u, zero while free; selects the datapath mux
module resource_pool_arbiter
    import resource_pool_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int NUM_UNITS = 1,
    parameter  int ID_WIDTH  = 4,
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0][ID_WIDTH+1:0]   rpl_in,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_REQ-1:0][UW-1:0]         grant_unit,
    output logic [NUM_UNITS-1:0]               unit_busy,
    output logic [NUM_UNITS-1:0][RW-1:0]       unit_owner
);

    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0]                rel;
    logic [NUM_REQ-1:0][ID_WIDTH-1:0]  ids;
    logic [NUM_REQ-1:0]                cand;
    logic [NUM_UNITS-1:0][NUM_REQ-1:0] pick;
    logic [NUM_UNITS-1:0]              releasing;
    logic [UW-1:0]                     slot;
    logic [NUM_REQ-1:0]                grant_d;
    logic [NUM_REQ-1:0][UW-1:0]        grant_unit_d;

    pool_unit_state_t units_q [NUM_UNITS];
    pool_unit_state_t units_d [NUM_UNITS];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = rpl_in[i][ID_WIDTH+1];
            ids[i] = rpl_in[i][RPL_ID_LSB +: ID_WIDTH];
            rel[i] = rpl_in[i][RPL_REL_BIT];
        end
    end

    // A current owner never re-enters arbitration, whatever its req does.
    assign cand = req & ~grant;

    resource_pool_arbiter_age_priority_select #(
        .NUM_REQ   (NUM_REQ),
        .NUM_UNITS (NUM_UNITS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_select (
        .cand (cand),
        .ids  (ids),
        .pick (pick)
    );

    // Only the current owner's release frees a unit; stray releases fall through.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            releasing[u] = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (units_q[u].busy && units_q[u].owner == POOL_OWNER_W'(i) && rel[i]) begin
                    releasing[u] = 1'b1;
                end
            end
        end
    end

    // Free view includes units releasing this cycle, so a waiting SIC takes
    // over with no dead cycle. The k-th free unit (ascending) goes to the k-th
    // oldest candidate.
    always_comb begin
        slot = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            units_d[u] = units_q[u];
            if (!units_q[u].busy || releasing[u]) begin
                units_d[u] = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pick[slot][i]) begin
                        units_d[u].busy  = 1'b1;
                        units_d[u].owner = POOL_OWNER_W'(i);
                    end
                end
                slot = slot + UW'(1);
            end
        end
    end

    // Grant outputs are registered copies of the owner decode of the next state.
    always_comb begin
        grant_d      = '0;
        grant_unit_d = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (units_d[u].busy && units_d[u].owner == POOL_OWNER_W'(i)) begin
                    grant_d[i]      = 1'b1;
                    grant_unit_d[i] = UW'(u);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                units_q[u] <= '0;
            end
            grant      <= '0;
            grant_unit <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                units_q[u] <= units_d[u];
            end
            grant      <= grant_d;
            grant_unit <= grant_unit_d;
        end
    end

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_busy[u]  = units_q[u].busy;
            unit_owner[u] = units_q[u].owner[RW-1:0];
        end
    end

    // Simulation-only consistency checks on the registered state.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($countones(grant) == $countones(unit_busy));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    assert (unit_busy[grant_unit[i]] && unit_owner[grant_unit[i]] == RW'(i));
                end
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                for (int v = u + 1; v < NUM_UNITS; v++) begin
                    if (unit_busy[u] && unit_busy[v]) begin
                        assert (unit_owner[u] != unit_owner[v]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_resource_pool_arbiter.sv
module tb_resource_pool_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Both pools (1 unit and 2 units) see the same SIC request bus.
    logic [3:0][5:0] rpl;
    logic [3:0]      g1, g2;
    logic [3:0][0:0] gu1, gu2;
    logic [0:0]      b1;
    logic [1:0]      b2;
    logic [0:0][1:0] o1;
    logic [1:0][1:0] o2;

    resource_pool_arbiter #(.NUM_REQ(4), .NUM_UNITS(1), .ID_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .rpl_in(rpl),
        .grant(g1), .grant_unit(gu1), .unit_busy(b1), .unit_owner(o1));

    resource_pool_arbiter #(.NUM_REQ(4), .NUM_UNITS(2), .ID_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .rpl_in(rpl),
        .grant(g2), .grant_unit(gu2), .unit_busy(b2), .unit_owner(o2));

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] gu;
        logic [1:0] busy;
        logic [3:0] owner;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;
    int   own [2][2];      // reference model: owner SIC per unit, -1 = free
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [3:0]      s_req, s_rel;
    logic [3:0][3:0] s_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit older(input int a, input int b);
        return ((a - b + 16) % 16) >= 8;
    endfunction

    // Reference model: one clock edge of pool d (d+1 units) given the current bus.
    task automatic model_step(input int d);
        int   nu;
        bit   held [4];
        int   cands[$];
        int   order[$];
        int   best;
        exp_t e;
        nu = d + 1;
        for (int i = 0; i < 4; i++) held[i] = 1'b0;
        for (int u = 0; u < nu; u++) if (own[d][u] >= 0) held[own[d][u]] = 1'b1;
        for (int u = 0; u < nu; u++)
            if (own[d][u] >= 0 && s_rel[own[d][u]]) own[d][u] = -1;
        for (int i = 0; i < 4; i++) if (s_req[i] && !held[i]) cands.push_back(i);
        while (cands.size() > 0) begin
            best = 0;
            for (int k = 1; k < cands.size(); k++)
                if (older(int'(s_id[cands[k]]), int'(s_id[cands[best]]))) best = k;
            order.push_back(cands[best]);
            cands.delete(best);
        end
        for (int u = 0; u < nu; u++)
            if (own[d][u] < 0 && order.size() > 0) own[d][u] = order.pop_front();
        e = '0;
        for (int u = 0; u < nu; u++) begin
            if (own[d][u] >= 0) begin
                e.grant[own[d][u]]  = 1'b1;
                e.gu[own[d][u]]     = 1'(u);
                e.busy[u]           = 1'b1;
                e.owner[2*u +: 2]   = 2'(own[d][u]);
            end
        end
        if (d == 0) q1.push_back(e);
        else        q2.push_back(e);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) for (int u = 0; u < 2; u++) own[d][u] = -1;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) rpl[i] = {s_req[i], s_id[i], s_rel[i]};
        model_step(0);
        model_step(1);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expectation per edge per pool.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            m1 = q1.pop_front();
            check("d1_grant",      32'(g1),  32'(m1.grant));
            check("d1_grant_unit", 32'(gu1), 32'(m1.gu));
            check("d1_unit_busy",  32'(b1),  32'(m1.busy[0]));
            check("d1_unit_owner", 32'(o1),  32'(m1.owner[1:0]));
        end
        if (q2.size() > 0) begin
            m2 = q2.pop_front();
            check("d2_grant",      32'(g2),  32'(m2.grant));
            check("d2_grant_unit", 32'(gu2), 32'(m2.gu));
            check("d2_unit_busy",  32'(b2),  32'(m2.busy));
            check("d2_unit_owner", 32'(o2),  32'(m2.owner));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_g1"}, 32'(g1), 0);
        check({tag, "_b1"}, 32'(b1), 0);
        check({tag, "_o1"}, 32'(o1), 0);
        check({tag, "_g2"}, 32'(g2), 0);
        check({tag, "_gu2"}, 32'(gu2), 0);
        check({tag, "_b2"}, 32'(b2), 0);
        check({tag, "_o2"}, 32'(o2), 0);
    endtask

    int st [4];
    int cnt [4];
    int next_id;

    function automatic bit window_ok();
        for (int i = 0; i < 4; i++)
            if ((st[i] == 1 || st[i] == 2) && ((next_id - int'(s_id[i]) + 16) % 16) >= 7) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        rst = 1'b1;
        rpl = '0;
        s_req = '0; s_rel = '0; s_id = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Solo: SIC0 id 3
        s_id[0] = 4'd3; s_req = 4'b0001; step();
        after_edge(); check("solo_grant", 32'(g1), 32'h1);
        step(); step(); step();
        s_req = 4'b0000; step();
        s_rel = 4'b0001; step();
        after_edge(); check("solo_release_grant", 32'(g1), 32'h0);
        check("solo_release_busy", 32'(b1), 32'h0);
        s_rel = 4'b0000; step();

        // Age: SIC0 id 7, SIC2 id 5
        s_id[0] = 4'd7; s_id[2] = 4'd5; s_req = 4'b0101; step();
        after_edge(); check("age_first", 32'(g1), 32'h4);
        step(); step();
        s_req = 4'b0001; step();
        s_rel = 4'b0100; step();
        after_edge(); check("age_handover", 32'(g1), 32'h1);
        s_rel = 4'b0000; s_req = 4'b0000; step();
        s_rel = 4'b0001; step();
        s_rel = 4'b0000; step();

        // Wrap: SIC1 id 15 older than SIC3 id 1
        s_id[1] = 4'd15; s_id[3] = 4'd1; s_req = 4'b1010; step();
        after_edge(); check("wrap_winner", 32'(g1), 32'h2);
        s_req = 4'b0000; step();
        s_rel = 4'b1010; step();
        s_rel = 4'b0000; step();

        // Bypass: SIC0 releases while SIC1 waits
        s_id[0] = 4'd4; s_req = 4'b0001; step();
        s_id[1] = 4'd5; s_req = 4'b0011; step();
        step();
        s_req = 4'b0010; step();
        s_rel = 4'b0001; step();
        after_edge(); check("bypass_grant", 32'(g1), 32'h2);
        s_rel = 4'b0000; s_req = 4'b0000; step();
        s_rel = 4'b0010; step();
        s_rel = 4'b0000; step();

        // Pool: ids 4,2,6,3 on two units
        s_id[0] = 4'd4; s_id[1] = 4'd2; s_id[2] = 4'd6; s_id[3] = 4'd3;
        s_req = 4'b1111; step();
        after_edge();
        check("pool_grant", 32'(g2), 32'hA);
        check("pool_owner", 32'(o2), 32'hD);
        check("pool_gunit", 32'(gu2), 32'h8);
        s_rel = 4'b0100; step();
        after_edge();
        check("stray_grant", 32'(g2), 32'hA);
        check("stray_owner", 32'(o2), 32'hD);
        s_rel = 4'b0000; step();

        // Reset while both units are held
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        s_req = '0; s_rel = '0;
        for (int i = 0; i < 4; i++) rpl[i] = '0;
        model_reset();
        check("reset_queues_empty", 32'(q1.size() + q2.size()), 0);
        rst = 1'b0;
        s_id[2] = 4'd8; s_req = 4'b0100; step();
        after_edge();
        check("post_reset_d1", 32'(g1), 32'h4);
        check("post_reset_d2", 32'(g2), 32'h4);
        s_req = 4'b0000; step();
        s_rel = 4'b0100; step();
        s_rel = 4'b0000; step();

        // Randomized SIC traffic: IDLE(0) -> WAIT(1) -> HOLD(2) -> DROP(3)
        next_id = 9;
        for (int i = 0; i < 4; i++) begin st[i] = 0; cnt[i] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_rel = '0;
            for (int i = 0; i < 4; i++) begin
                case (st[i])
                    0: begin
                        s_req[i] = 1'b0;
                        if ($urandom_range(0, 2) == 0 && window_ok()) begin
                            s_id[i] = 4'(next_id);
                            next_id = (next_id + 1) % 16;
                            s_req[i] = 1'b1;
                            st[i] = 1;
                        end else if ($urandom_range(0, 15) == 0) begin
                            s_rel[i] = 1'b1;
                        end
                    end
                    1: begin
                        if (own[1][0] == i || own[1][1] == i) begin
                            st[i] = 2;
                            cnt[i] = $urandom_range(0, 3);
                        end else if ($urandom_range(0, 9) == 0) begin
                            s_req[i] = 1'b0;
                            st[i] = 3;
                        end
                    end
                    2: begin
                        if (cnt[i] == 0) begin
                            s_req[i] = 1'b0;
                            st[i] = 3;
                        end else begin
                            cnt[i]--;
                        end
                    end
                    default: begin
                        s_req[i] = 1'b0;
                        s_rel[i] = 1'b1;
                        st[i] = 0;
                    end
                endcase
            end
            step();
        end

        s_req = '0; s_rel = '0;
        step(); step();
        @(posedge clk);
        #2;
        check("queue_drain", 32'(q1.size() + q2.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
